dot_product_ctrl: RTL and testbench

Sequencer for the dot-product datapath. On a start request it streams reads from two synchronous single-port-read vector memories, A and B, which have 1-cycle read latency. It multiplies each returned element pair and accumulates the products. It then presents the unsigned dot product with a one-cycle done pulse, and sits between the host/control logic and the two memory instances' read ports.

---
 rtl/dot_product_ctrl_if.sv | 30 +++
 rtl/dot_product_ctrl.sv | 121 ++++++++++++
 tb/tb_dot_product_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_ctrl_if.sv
// Host and memory-read signals of the dot-product sequencer.
// master = host/memory side, slave = controller side.
interface dot_product_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_b;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  busy;
  logic                  done;
  logic [ACC_WIDTH-1:0]  result;

  modport master (
    output start, len, base_a, base_b, data_a, data_b,
    input  rd_en, rd_addr_a, rd_addr_b, busy, done, result
  );

  modport slave (
    input  start, len, base_a, base_b, data_a, data_b,
    output rd_en, rd_addr_a, rd_addr_b, busy, done, result
  );
endinterface

// File: rtl/dot_product_ctrl.sv
// Streams element pairs out of memories A and B, multiply-accumulates them
// and presents the unsigned dot product with a one-cycle done pulse.
//
// state   | meaning
// S_IDLE  | waiting for start; len/base sampled here
// S_READ  | issuing one read per cycle, cnt_q reads remaining
// S_DRAIN | last read data returning, final accumulate into result
// S_DONE  | done pulse, back to idle
module dot_product_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  dot_product_ctrl_if.slave  bus
);
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                  pend_q, pend_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [LEN_W-1:0]        len_sat;
  logic [2*DATA_WIDTH-1:0] prod_full;
  logic [ACC_WIDTH-1:0]    acc_sum;

  assign len_sat   = (bus.len > DEPTH) ? DEPTH : bus.len;
  assign prod_full = bus.data_a * bus.data_b;
  assign acc_sum   = acc_q + ACC_WIDTH'(prod_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_en_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      pend_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_en_q  <= rd_en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (len_sat == '0) ? S_DONE : S_READ;
      S_READ:  if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    result_d = result_q;
    pend_d   = rd_en_q;
    acc_d    = pend_q ? acc_sum : acc_q;
    rd_en_d  = (state_d == S_READ);
    busy_d   = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = len_sat;
          acc_d = '0;
          if (len_sat == '0) begin
            result_d = '0;
          end else begin
            addr_a_d = bus.base_a;
            addr_b_d = bus.base_b;
          end
        end
      end
      S_READ: begin
        // cnt_q is a remaining-reads down-counter; addresses freeze on the last read
        cnt_d = cnt_q - LEN_W'(1);
        if (state_d == S_READ) begin
          addr_a_d = addr_a_q + ADDR_WIDTH'(1);
          addr_b_d = addr_b_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: result_d = acc_sum;
      default: ;
    endcase
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = addr_a_q;
  assign bus.rd_addr_b = addr_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Scoreboard bench for dot_product_ctrl: expected addresses, results and
// done timing are queued at start and popped as the DUT produces them.
module tb_dot_product_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int ACCW  = 2*DW+AW;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) bus ();
  dot_product_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  // synchronous-read memories, 1-cycle latency
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.data_a <= mem_a[bus.rd_addr_a];
      bus.data_b <= mem_b[bus.rd_addr_b];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [AW-1:0] q_addr_a [$];
  logic [AW-1:0] q_addr_b [$];
  logic [31:0]   q_res [$];
  int            q_cyc [$];
  bit            mon_en = 1'b0;
  logic [31:0]   last_res = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_en) begin
        check_eq("busy_rd", 32'(bus.busy), 32'd1);
        if (q_addr_a.size() == 0) begin
          check_eq("rd_expected", 32'(bus.rd_en), 32'd0);
        end else begin
          check_eq("rd_addr_a", 32'(bus.rd_addr_a), 32'(q_addr_a.pop_front()));
          check_eq("rd_addr_b", 32'(bus.rd_addr_b), 32'(q_addr_b.pop_front()));
        end
      end
      if (bus.done) begin
        if (q_res.size() == 0) begin
          check_eq("done_expected", 32'(bus.done), 32'd0);
        end else begin
          check_eq("result", 32'(bus.result), q_res.pop_front());
          check_eq("done_cyc", 32'(cyc), 32'(q_cyc.pop_front()));
          last_res = 32'(bus.result);
        end
      end
    end
  end

  task automatic flush_sb();
    q_addr_a.delete();
    q_addr_b.delete();
    q_res.delete();
    q_cyc.delete();
  endtask

  // call at #1 after a rising edge with the DUT idle
  task automatic start_op(input int n, input logic [AW-1:0] ba, input logic [AW-1:0] bb);
    int ns;
    logic [31:0] acc;
    logic [AW-1:0] a, b;
    ns  = (n > DEPTH) ? DEPTH : n;
    acc = '0;
    a   = ba;
    b   = bb;
    for (int i = 0; i < ns; i++) begin
      q_addr_a.push_back(a);
      q_addr_b.push_back(b);
      acc = acc + 32'(mem_a[a]) * 32'(mem_b[b]);
      a++;
      b++;
    end
    q_res.push_back(acc);
    q_cyc.push_back(cyc + 1 + ((ns > 0) ? ns + 1 : 0));
    bus.len    = 5'(n);
    bus.base_a = ba;
    bus.base_b = bb;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (q_res.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q_res.size() != 0) begin
      check_eq("timeout", 32'(q_res.size()), 32'd0);
      flush_sb();
    end
    check_eq("rd_left", 32'(q_addr_a.size()), 32'd0);
    check_eq("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.len    = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'($urandom_range(255));
      mem_b[i] = 8'($urandom_range(255));
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_addr_a", 32'(bus.rd_addr_a), 32'd0);
    check_eq("rst_addr_b", 32'(bus.rd_addr_b), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // basic run
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    start_op(4, 4'd0, 4'd0);
    wait_done(40);
    check_eq("basic_70", last_res, 32'd70);

    // start during READ is ignored
    start_op(4, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    bus.len    = 5'd9;
    bus.base_a = 4'd3;
    bus.base_b = 4'd7;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(40);
    check_eq("ignored_start_70", last_res, 32'd70);

    // back-to-back: old result held until new done
    start_op(6, 4'd5, 4'd9);
    repeat (4) begin
      @(negedge clk);
      check_eq("res_hold", 32'(bus.result), 32'd70);
    end
    wait_done(40);

    // full scale
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'hFF;
    end
    start_op(16, 4'd0, 4'd0);
    wait_done(60);
    check_eq("full_res", last_res, 32'hFE010);

    // wrap, then saturation
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'($urandom_range(255));
      mem_b[i] = 8'($urandom_range(255));
    end
    start_op(4, 4'd14, 4'd2);
    wait_done(40);
    start_op(20, 4'd14, 4'd2);
    wait_done(60);

    // zero length
    start_op(0, 4'd3, 4'd3);
    repeat (3) begin
      @(negedge clk);
      check_eq("zero_rd_en", 32'(bus.rd_en), 32'd0);
      check_eq("zero_busy", 32'(bus.busy), 32'd0);
    end
    wait_done(10);
    check_eq("zero_res", last_res, 32'd0);
    @(posedge clk);
    #1;

    // reset mid-operation
    start_op(10, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    flush_sb();
    check_eq("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_done", 32'(bus.done), 32'd0);
    check_eq("mid_rst_result", 32'(bus.result), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    start_op(5, 4'd1, 4'd1);
    wait_done(40);

    check_eq("sb_empty", 32'(q_res.size() + q_addr_a.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
